seq_divide_hs: RTL and testbench
================================

# seq_divide_hs

Multi-cycle restoring integer divider computing a = b*q + r, with valid/ready handshakes on input and output. It supports signed and unsigned operands per operation and a parametrised number of quotient bits per cycle. Divide-by-zero is detected and flagged. It sits between an issue stage and a writeback stage and replaces the free-running start/finish divider where backpressure and signed operation are needed.

## Interface
- WidthA, 32: dividend and quotient width; WidthA >= 2 and WidthA % Steps == 0
- WidthB, 32: divisor and remainder width; WidthB >= 2
- Steps, 1: quotient bits resolved per cycle; legal values 1, 2, 4
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- in_valid_i  in  1  operands valid
- in_ready_o  out  1  divider can accept; reset 1
- a_i  in  WidthA  dividend
- b_i  in  WidthB  divisor
- signed_i  in  1  1: two's-complement operands; 0: unsigned
- out_valid_o  out  1  result valid; reset 0
- out_ready_i  in  1  consumer accepts result
- q_o  out  WidthA  quotient; reset 0
- r_o  out  WidthB  remainder; reset 0
- div_zero_o  out  1  b was zero for this result; reset 0
- busy_o  out  1  state != IDLE; reset 0

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i, capture operands, set sign flags (signed_i & MSB), and store |a| and |b| (absolute values only when signed).
  - b == 0: go to DONE with q = all ones, r = a_i[WidthB-1:0] (zero-extended if WidthA < WidthB), div_zero = 1.
  - Otherwise: clear the partial remainder (WidthB+1 bits) and go to CALC.
- CALC:
  - Each cycle performs Steps restoring iterations. Per iteration: shift in the next dividend MSB, trial-subtract |b|, and set the quotient bit to 1 when the result is non-negative.
  - Iteration counter is WidthA/Steps cycles, counting down. At zero, go to FIX.
- FIX:
  - Signed only:
    - Negate q if sign(a) XOR sign(b).
    - Negate r if sign(a).
  - Rounding is toward zero; the remainder takes the sign of the dividend.
  - Signed min / -1 yields q = min (wraps), r = 0.
  - Go to DONE.
- DONE:
  - out_valid_o = 1. q_o, r_o and div_zero_o are held stable until out_valid_o & out_ready_i, then go to IDLE.
- in_ready_o is 1 only in IDLE. There is no overlap of a new accept with DONE.
- Outputs are registered. q_o, r_o and div_zero_o keep their last value in IDLE. They are undefined while busy and must not be sampled.
- Reset at any state: state IDLE, counter 0, all outputs at reset values. The in-flight operation is dropped.

## Timing
- N = WidthA/Steps.
- Accept at edge T: CALC occupies cycles T+1..T+N, FIX occupies T+N+1, and out_valid_o rises in cycle T+N+2. Latency is N+2 cycles from accept to out_valid.
- Divide-by-zero: out_valid_o in cycle T+1.
- Unsigned operations still pass through FIX, so latency is independent of operand values and mode.
- Result handshake at edge U: in_ready_o = 1 in cycle U+1. The earliest next accept is edge U+1.
- Throughput: one operation per N+3 cycles with out_ready_i tied high.
- signed_i, a_i and b_i are sampled only on the accept edge. Later changes have no effect.

## Structure
- Package seq_divide_pkg:
  - State enum div_state_e (IDLE, CALC, FIX, DONE).
  - Parameter-check function for legal Steps values.
  - Localparam helper for counter width: $clog2(WidthA/Steps + 1).
- Sub-module seq_divide_step: a combinational chain of Steps restoring iterations, parametrised on WidthB and Steps. Inputs are partial remainder, divisor magnitude and the next Steps dividend bits. Outputs are the new partial remainder and Steps quotient bits. The top level instantiates it once.
- Elaboration-time assertions:
  - WidthA % Steps == 0.
  - Steps is in {1, 2, 4}.
  - WidthA >= 2 and WidthB >= 2.

## Test plan
- WidthA=WidthB=8, Steps=1, unsigned 100/7: q=14, r=2, div_zero=0. out_valid in cycle T+10.
- Signed -7/2 (0xF9/0x02): q=0xFD (-3), r=0xFF (-1). Signed 7/-2: q=0xFD, r=0x01.
- Signed 0x80/0xFF (-128/-1): q=0x80, r=0x00, no flag.
- Divide-by-zero: 0x55/0x00, both modes. q=0xFF, r=0x55, div_zero=1, out_valid in cycle T+1.
- Backpressure: out_ready_i low for 5 cycles after out_valid. Outputs stable, in_ready_o=0, a second in_valid_i is ignored. Accept on the cycle after release.
- Reset mid-CALC, then Steps=2: after the rst_i pulse, busy_o=0, out_valid_o=0, in_ready_o=1. Next, 200/3 unsigned: q=66, r=2, out_valid in cycle T+6.

Source files
------------

// File: rtl/seq_divide_pkg.sv
// Shared types and elaboration helpers for the sequential handshake divider.
package seq_divide_pkg;

    // Controller states of the divider.
    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } div_state_e;

    // Quotient bits resolved per cycle must be 1, 2 or 4.
    function automatic bit steps_legal(input int unsigned steps);
        return (steps == 1) || (steps == 2) || (steps == 4);
    endfunction

    // Width of a down-counter that must hold WidthA/Steps.
    function automatic int unsigned cnt_width(input int unsigned width_a,
                                              input int unsigned steps);
        return $clog2(width_a / steps + 1);
    endfunction

endpackage

// File: rtl/seq_divide_step.sv
// Combinational chain of Steps restoring-division iterations.
module seq_divide_step
    import seq_divide_pkg::*;
#(
    parameter int unsigned WidthB = 32,
    parameter int unsigned Steps  = 1
) (
    input  logic [WidthB:0]   rem_i,
    input  logic [WidthB-1:0] b_i,
    input  logic [Steps-1:0]  bits_i,
    output logic [WidthB:0]   rem_o,
    output logic [Steps-1:0]  q_o
);

    logic [WidthB:0]   rem;
    logic [WidthB+1:0] sh;
    logic [WidthB+1:0] diff;

    // MSB-first: bits_i[Steps-1] is shifted in first and yields q_o[Steps-1].
    always_comb begin
        rem  = rem_i;
        sh   = '0;
        diff = '0;
        q_o  = '0;
        for (int i = Steps - 1; i >= 0; i--) begin
            sh   = {rem, bits_i[i]};
            diff = sh - {2'b00, b_i};
            if (!diff[WidthB+1]) begin
                rem    = diff[WidthB:0];
                q_o[i] = 1'b1;
            end else begin
                rem = sh[WidthB:0];
            end
        end
        rem_o = rem;
    end

endmodule

// File: rtl/seq_divide_hs.sv
// Multi-cycle restoring divider (a = b*q + r) with valid/ready on both sides,
// signed/unsigned per operation and divide-by-zero flagging.
module seq_divide_hs
    import seq_divide_pkg::*;
#(
    parameter int unsigned WidthA = 32,
    parameter int unsigned WidthB = 32,
    parameter int unsigned Steps  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WidthA-1:0] a_i,
    input  logic [WidthB-1:0] b_i,
    input  logic              signed_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WidthA-1:0] q_o,
    output logic [WidthB-1:0] r_o,
    output logic              div_zero_o,
    output logic              busy_o
);

    localparam int unsigned CntW = cnt_width(WidthA, Steps);
    localparam int unsigned NCyc = WidthA / Steps;
    localparam int unsigned WMax = (WidthA > WidthB) ? WidthA : WidthB;

    if (WidthA % Steps != 0) begin : g_bad_div
        $fatal(1, "seq_divide_hs: WidthA must be a multiple of Steps");
    end
    if (!steps_legal(Steps)) begin : g_bad_steps
        $fatal(1, "seq_divide_hs: Steps must be 1, 2 or 4");
    end
    if (WidthA < 2 || WidthB < 2) begin : g_bad_width
        $fatal(1, "seq_divide_hs: WidthA and WidthB must be at least 2");
    end

    div_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    // Dividend magnitude; quotient bits shift in from the LSB as it drains.
    logic [WidthA-1:0] a_q, a_d;
    logic [WidthB:0]   rem_q, rem_d;
    logic [WidthB-1:0] bmag_q, bmag_d;
    logic              neg_q_q, neg_q_d;
    logic              neg_r_q, neg_r_d;
    logic [WidthA-1:0] q_q, q_d;
    logic [WidthB-1:0] r_q, r_d;
    logic              dz_q, dz_d;

    logic              sign_a, sign_b;
    logic [WMax-1:0]   a_wide;
    logic [WidthB:0]   step_rem;
    logic [Steps-1:0]  step_q;

    seq_divide_step #(
        .WidthB (WidthB),
        .Steps  (Steps)
    ) u_step (
        .rem_i  (rem_q),
        .b_i    (bmag_q),
        .bits_i (a_q[WidthA-1 -: Steps]),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    // Next-state and datapath updates for the controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        rem_d   = rem_q;
        bmag_d  = bmag_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        sign_a  = signed_i & a_i[WidthA-1];
        sign_b  = signed_i & b_i[WidthB-1];
        a_wide  = WMax'(a_i);

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = sign_a ? -a_i : a_i;
                    bmag_d  = sign_b ? -b_i : b_i;
                    neg_q_d = sign_a ^ sign_b;
                    neg_r_d = sign_a;
                    rem_d   = '0;
                    if (b_i == '0) begin
                        q_d     = '1;
                        r_d     = a_wide[WidthB-1:0];
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        cnt_d   = CntW'(NCyc);
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = step_rem;
                a_d   = (a_q << Steps) | WidthA'(step_q);
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                // Truncating division: remainder follows the dividend's sign.
                q_d     = neg_q_q ? -a_q : a_q;
                r_d     = neg_r_q ? -rem_q[WidthB-1:0] : rem_q[WidthB-1:0];
                dz_d    = 1'b0;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            rem_q   <= '0;
            bmag_q  <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            rem_q   <= rem_d;
            bmag_q  <= bmag_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign q_o         = q_q;
    assign r_o         = r_q;
    assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_seq_divide_hs.sv
// Directed bench for seq_divide_hs: one Steps=1 and one Steps=2 instance, 8-bit operands.
module tb_seq_divide_hs;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      in_valid;
    logic [1:0]      in_ready;
    logic [1:0][7:0] a;
    logic [1:0][7:0] b;
    logic [1:0]      sgn;
    logic [1:0]      out_valid;
    logic [1:0]      out_ready;
    logic [1:0][7:0] q;
    logic [1:0][7:0] r;
    logic [1:0]      dz;
    logic [1:0]      busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divide_hs #(
        .WidthA (8),
        .WidthB (8),
        .Steps  (1)
    ) u_dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid[0]),
        .in_ready_o  (in_ready[0]),
        .a_i         (a[0]),
        .b_i         (b[0]),
        .signed_i    (sgn[0]),
        .out_valid_o (out_valid[0]),
        .out_ready_i (out_ready[0]),
        .q_o         (q[0]),
        .r_o         (r[0]),
        .div_zero_o  (dz[0]),
        .busy_o      (busy[0])
    );

    seq_divide_hs #(
        .WidthA (8),
        .WidthB (8),
        .Steps  (2)
    ) u_dut2 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid[1]),
        .in_ready_o  (in_ready[1]),
        .a_i         (a[1]),
        .b_i         (b[1]),
        .signed_i    (sgn[1]),
        .out_valid_o (out_valid[1]),
        .out_ready_i (out_ready[1]),
        .q_o         (q[1]),
        .r_o         (r[1]),
        .div_zero_o  (dz[1]),
        .busy_o      (busy[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, check latency and result; leaves the DUT in DONE.
    task automatic run_op(input int s, input logic [7:0] av, input logic [7:0] bv,
                          input logic sg, input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input int elat, input string tag);
        int cyc;
        check_eq({tag, ".in_ready_pre"}, in_ready[s], 1);
        a[s] = av; b[s] = bv; sgn[s] = sg; in_valid[s] = 1'b1;
        @(posedge clk); #1;
        // Scramble operands after accept; b=0 would flag div-zero if resampled.
        in_valid[s] = 1'b0; a[s] = ~av; b[s] = 8'h00; sgn[s] = ~sg;
        cyc = 1;
        check_eq({tag, ".in_ready_busy"}, in_ready[s], 0);
        while (!out_valid[s] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, ".latency"}, cyc, elat);
        check_eq({tag, ".q"}, q[s], eq);
        check_eq({tag, ".r"}, r[s], er);
        check_eq({tag, ".dz"}, dz[s], edz);
    endtask

    // Complete the result handshake and confirm return to IDLE.
    task automatic finish_op(input int s, input string tag);
        out_ready[s] = 1'b1;
        @(posedge clk); #1;
        out_ready[s] = 1'b0;
        check_eq({tag, ".out_valid_post"}, out_valid[s], 0);
        check_eq({tag, ".in_ready_post"}, in_ready[s], 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0; a = '0; b = '0; sgn = '0; out_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("rst.in_ready", in_ready[0], 1);
        check_eq("rst.out_valid", out_valid[0], 0);
        check_eq("rst.busy", busy[0], 0);
        check_eq("rst.q", q[0], 0);
        check_eq("rst.r", r[0], 0);
        check_eq("rst.dz", dz[0], 0);

        // Unsigned 100/7 with backpressure held for 5 cycles.
        run_op(0, 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 10, "u100_7");
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1; a[0] = 8'h11; b[0] = 8'h01; sgn[0] = 1'b0;
            @(posedge clk); #1;
            check_eq("bp.out_valid", out_valid[0], 1);
            check_eq("bp.in_ready", in_ready[0], 0);
            check_eq("bp.q", q[0], 8'd14);
            check_eq("bp.r", r[0], 8'd2);
        end
        in_valid[0] = 1'b0;
        finish_op(0, "bp");

        // Accepted on the cycle after release.
        run_op(0, 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 10, "s_m7_2");
        finish_op(0, "s_m7_2");
        run_op(0, 8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 10, "s_7_m2");
        finish_op(0, "s_7_m2");
        run_op(0, 8'hF9, 8'h02, 1'b0, 8'h7C, 8'h01, 1'b0, 10, "u249_2");
        finish_op(0, "u249_2");
        run_op(0, 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 10, "s_min_m1");
        finish_op(0, "s_min_m1");
        run_op(0, 8'h55, 8'h00, 1'b0, 8'hFF, 8'h55, 1'b1, 1, "u_dz");
        finish_op(0, "u_dz");
        check_eq("idle_hold.q", q[0], 8'hFF);
        check_eq("idle_hold.dz", dz[0], 1);
        run_op(0, 8'h55, 8'h00, 1'b1, 8'hFF, 8'h55, 1'b1, 1, "s_dz");
        finish_op(0, "s_dz");
        run_op(0, 8'd5, 8'd9, 1'b0, 8'd0, 8'd5, 1'b0, 10, "u5_9");
        finish_op(0, "u5_9");
        run_op(0, 8'd255, 8'd255, 1'b0, 8'd1, 8'd0, 1'b0, 10, "u255_255");
        finish_op(0, "u255_255");

        // Reset in the middle of CALC on the Steps=2 instance.
        a[1] = 8'd77; b[1] = 8'd5; sgn[1] = 1'b0; in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        @(posedge clk); #1;
        check_eq("mid.busy", busy[1], 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst2.busy", busy[1], 0);
        check_eq("rst2.out_valid", out_valid[1], 0);
        check_eq("rst2.in_ready", in_ready[1], 1);
        check_eq("rst2.q", q[1], 0);
        run_op(1, 8'd200, 8'd3, 1'b0, 8'd66, 8'd2, 1'b0, 6, "s2_u200_3");
        finish_op(1, "s2_u200_3");
        run_op(1, 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 6, "s2_m7_2");
        finish_op(1, "s2_m7_2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
